multicycle_control_fsm: RTL and testbench

Moore state-machine controller that sequences a shared-memory, single-ALU MIPS datapath over 3-5 cycles per instruction. It replaces the combinational opcode decoder for the multicycle core and supports the same instruction set: R-type, addi, andi, ori, slti, lw, sw, beq and j. It sits between the instruction register's opcode field and the datapath mux/enable inputs, and adds a memory wait handshake, an illegal-opcode flag and a retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 76 +++++++
 rtl/mc_output_decode.sv | 76 +++++++
 rtl/multicycle_control_fsm.sv | 120 ++++++++++++
 tb/tb_multicycle_control_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU op codes,
// mux select codes, FSM state encodings and the control vector layout.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // AluOp codes
    localparam logic [2:0] ALU_FUNCT = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b110;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b101;

    // AluSrcB selects
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJump     = 4'd11
    } stateT;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSrc;
    } ctrlT;

    // ALU operation for the immediate-arithmetic group; add for anything else.
    function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
        logic [2:0] aluOp;
        aluOp = ALU_ADD;
        if (op == OP_ANDI) aluOp = ALU_AND;
        if (op == OP_ORI)  aluOp = ALU_OR;
        if (op == OP_SLTI) aluOp = ALU_SLT;
        return aluOp;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: current state (plus op where the action depends on it)
// to the datapath control vector.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  stateT      state,
    input  logic [5:0] op,
    input  logic       memReady,
    output ctrlT       ctrl
);

    // Every control defaults to 0; each state raises only what it needs.
    always_comb begin
        ctrl = '0;
        unique case (state)
            StIdle: ;
            StFetch: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluOp   = ALU_ADD;
                ctrl.pcSrc   = PCSRC_ALU;
                // PC and IR only commit once the fetch data is actually there
                ctrl.pcWrite = memReady;
                ctrl.irWrite = memReady;
            end
            StDecode: begin
                ctrl.aluSrcB = SRCB_IMMSH2;
                ctrl.aluOp   = ALU_ADD;
            end
            StMemAddr: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            StMemRead: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            StMemWb: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            StMemWrite: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            StExecR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluOp   = ALU_FUNCT;
            end
            StExecI: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = iTypeAluOp(op);
            end
            StAluWb: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = (op == OP_RTYPE);
            end
            StBranch: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_RT;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSrc       = PCSRC_ALUOUT;
            end
            StJump: begin
                ctrl.pcWrite = 1'b1;
                ctrl.pcSrc   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: state sequencing, illegal-opcode flag and
// retired-instruction counter. Control outputs come from mc_output_decode.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [2:0]       AluOp,
    output logic [1:0]       PCSrc,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    stateT            stateQ, stateD;
    logic             illegalQ, illegalD;
    logic             retireEvent;
    logic [CNT_W-1:0] retiredQ;
    logic             memReadyEff;
    ctrlT             ctrlVec;

    assign memReadyEff = (FETCH_WAIT != 0) ? mem_ready : 1'b1;

    // Next-state selection, illegal-opcode detection and retirement detection.
    always_comb begin
        stateD      = stateQ;
        illegalD    = 1'b0;
        retireEvent = 1'b0;
        unique case (stateQ)
            StIdle:  if (run) stateD = StFetch;
            StFetch: if (memReadyEff) stateD = StDecode;
            StDecode: begin
                unique case (op)
                    OP_RTYPE:                         stateD = StExecR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: stateD = StExecI;
                    OP_LW, OP_SW:                     stateD = StMemAddr;
                    OP_BEQ:                           stateD = StBranch;
                    OP_J:                             stateD = StJump;
                    default: begin
                        stateD   = StFetch;
                        illegalD = 1'b1;
                    end
                endcase
            end
            StMemAddr: stateD = (op == OP_LW) ? StMemRead : StMemWrite;
            StMemRead: if (memReadyEff) stateD = StMemWb;
            StMemWb: begin
                stateD      = StFetch;
                retireEvent = 1'b1;
            end
            StMemWrite: begin
                if (memReadyEff) begin
                    stateD      = StFetch;
                    retireEvent = 1'b1;
                end
            end
            StExecR, StExecI: stateD = StAluWb;
            StAluWb, StBranch, StJump: begin
                stateD      = StFetch;
                retireEvent = 1'b1;
            end
            default: stateD = StIdle;
        endcase
    end

    // State, illegal-opcode pulse and retired counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            illegalQ <= 1'b0;
            retiredQ <= '0;
        end else begin
            stateQ   <= stateD;
            illegalQ <= illegalD;
            if (retireEvent) retiredQ <= retiredQ + CNT_W'(1);
        end
    end

    mc_output_decode uOutputDecode (
        .state    (stateQ),
        .op       (op),
        .memReady (memReadyEff),
        .ctrl     (ctrlVec)
    );

    assign PCWrite     = ctrlVec.pcWrite;
    assign PCWriteCond = ctrlVec.pcWriteCond;
    assign IorD        = ctrlVec.iorD;
    assign MemRead     = ctrlVec.memRead;
    assign MemWrite    = ctrlVec.memWrite;
    assign IRWrite     = ctrlVec.irWrite;
    assign MemToReg    = ctrlVec.memToReg;
    assign RegDst      = ctrlVec.regDst;
    assign RegWrite    = ctrlVec.regWrite;
    assign AluSrcA     = ctrlVec.aluSrcA;
    assign AluSrcB     = ctrlVec.aluSrcB;
    assign AluOp       = ctrlVec.aluOp;
    assign PCSrc       = ctrlVec.pcSrc;
    assign illegal_op  = illegalQ;
    assign retired     = retiredQ;
    assign state_dbg   = stateQ;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver pushes the expected
// per-cycle state/control/flag/counter record; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  op;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, AluSrcA;
    logic [1:0]  AluSrcB, PCSrc;
    logic [2:0]  AluOp;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    multicycle_control_fsm #(.CNT_W(32), .FETCH_WAIT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .op          (op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .AluSrcA     (AluSrcA),
        .AluSrcB     (AluSrcB),
        .AluOp       (AluOp),
        .PCSrc       (PCSrc),
        .illegal_op  (illegal_op),
        .retired     (retired),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Opcodes
    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

    // Control vector order:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,
    //  AluSrcA,AluSrcB[1:0],AluOp[2:0],PCSrc[1:0]}
    localparam logic [16:0] V_IDLE    = 17'b0;
    localparam logic [16:0] V_FETCH   = {10'b1001010000, 2'b01, 3'b110, 2'b00};
    localparam logic [16:0] V_FETCHNR = {10'b0001000000, 2'b01, 3'b110, 2'b00};
    localparam logic [16:0] V_DECODE  = {10'b0000000000, 2'b11, 3'b110, 2'b00};
    localparam logic [16:0] V_MADDR   = {10'b0000000001, 2'b10, 3'b110, 2'b00};
    localparam logic [16:0] V_MREAD   = {10'b0011000000, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] V_MWB     = {10'b0000001010, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] V_MWRITE  = {10'b0010100000, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] V_EXECR   = {10'b0000000001, 2'b00, 3'b001, 2'b00};
    localparam logic [16:0] V_EXECADD = {10'b0000000001, 2'b10, 3'b110, 2'b00};
    localparam logic [16:0] V_EXECOR  = {10'b0000000001, 2'b10, 3'b100, 2'b00};
    localparam logic [16:0] V_WBR     = {10'b0000000110, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] V_WBI     = {10'b0000000010, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] V_BRANCH  = {10'b0100000001, 2'b00, 3'b101, 2'b01};
    localparam logic [16:0] V_JUMP    = {10'b1000000000, 2'b00, 3'b000, 2'b10};

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [16:0] cv;
        logic        ill;
        logic [31:0] ret;
    } expT;

    expT expQ[$];
    int  nTests = 0;
    int  nFail  = 0;
    int  cycIdx = 0;

    logic [16:0] actCv;
    assign actCv = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                    RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSrc};

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: one expected record per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            chk("state", e.idx, {28'b0, state_dbg}, {28'b0, e.st});
            chk("ctrl", e.idx, {15'b0, actCv}, {15'b0, e.cv});
            chk("illegal_op", e.idx, {31'b0, illegal_op}, {31'b0, e.ill});
            chk("retired", e.idx, retired, e.ret);
        end
    end

    // Drive inputs for one cycle and queue what the DUT must show in it.
    task automatic cyc(input logic r, input logic rn, input logic [5:0] o, input logic mr,
                       input logic [3:0] st, input logic [16:0] cv, input logic il,
                       input logic [31:0] ret);
        expT e;
        rst_n     = r;
        run       = rn;
        op        = o;
        mem_ready = mr;
        e.idx = cycIdx;
        e.st  = st;
        e.cv  = cv;
        e.ill = il;
        e.ret = ret;
        expQ.push_back(e);
        cycIdx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; op = RT; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Reset state
        cyc(0, 0, RT, 1, 0, V_IDLE, 0, 0);
        cyc(0, 0, RT, 1, 0, V_IDLE, 0, 0);
        cyc(1, 0, RT, 1, 0, V_IDLE, 0, 0);
        // lw: 0,1,2,3,4,5,1
        cyc(1, 1, LW, 1, 0,  V_IDLE,   0, 0);
        cyc(1, 0, LW, 1, 1,  V_FETCH,  0, 0);
        cyc(1, 0, LW, 1, 2,  V_DECODE, 0, 0);
        cyc(1, 0, LW, 1, 3,  V_MADDR,  0, 0);
        cyc(1, 0, LW, 1, 4,  V_MREAD,  0, 0);
        cyc(1, 0, LW, 1, 5,  V_MWB,    0, 0);
        // R-type
        cyc(1, 0, RT, 1, 1,  V_FETCH,  0, 1);
        cyc(1, 0, RT, 1, 2,  V_DECODE, 0, 1);
        cyc(1, 0, RT, 1, 7,  V_EXECR,  0, 1);
        cyc(1, 0, RT, 1, 9,  V_WBR,    0, 1);
        // sw with memory stalling 3 cycles
        cyc(1, 0, SW, 1, 1,  V_FETCH,  0, 2);
        cyc(1, 0, SW, 1, 2,  V_DECODE, 0, 2);
        cyc(1, 0, SW, 1, 3,  V_MADDR,  0, 2);
        cyc(1, 0, SW, 0, 6,  V_MWRITE, 0, 2);
        cyc(1, 0, SW, 0, 6,  V_MWRITE, 0, 2);
        cyc(1, 0, SW, 0, 6,  V_MWRITE, 0, 2);
        cyc(1, 0, SW, 1, 6,  V_MWRITE, 0, 2);
        // beq (run held high: must be ignored outside IDLE)
        cyc(1, 1, BEQ, 1, 1,  V_FETCH,  0, 3);
        cyc(1, 1, BEQ, 1, 2,  V_DECODE, 0, 3);
        cyc(1, 1, BEQ, 1, 10, V_BRANCH, 0, 3);
        // j
        cyc(1, 0, JMP, 1, 1,  V_FETCH,  0, 4);
        cyc(1, 0, JMP, 1, 2,  V_DECODE, 0, 4);
        cyc(1, 0, JMP, 1, 11, V_JUMP,   0, 4);
        // illegal opcode: pulse in the following FETCH, count unchanged
        cyc(1, 0, BAD, 1, 1,  V_FETCH,  0, 5);
        cyc(1, 0, BAD, 1, 2,  V_DECODE, 0, 5);
        // addi
        cyc(1, 0, ADDI, 1, 1, V_FETCH,   1, 5);
        cyc(1, 0, ADDI, 1, 2, V_DECODE,  0, 5);
        cyc(1, 0, ADDI, 1, 8, V_EXECADD, 0, 5);
        cyc(1, 0, ADDI, 1, 9, V_WBI,     0, 5);
        // ori
        cyc(1, 0, ORI, 1, 1,  V_FETCH,  0, 6);
        cyc(1, 0, ORI, 1, 2,  V_DECODE, 0, 6);
        cyc(1, 0, ORI, 1, 8,  V_EXECOR, 0, 6);
        cyc(1, 0, ORI, 1, 9,  V_WBI,    0, 6);
        // ori interrupted by reset in EXEC_I
        cyc(1, 0, ORI, 1, 1,  V_FETCH,  0, 7);
        cyc(1, 0, ORI, 1, 2,  V_DECODE, 0, 7);
        cyc(0, 0, ORI, 1, 0,  V_IDLE,   0, 0);
        cyc(1, 0, ORI, 1, 0,  V_IDLE,   0, 0);
        cyc(1, 0, ORI, 1, 0,  V_IDLE,   0, 0);
        cyc(1, 0, ORI, 1, 0,  V_IDLE,   0, 0);
        // restart; fetch stalls one cycle on mem_ready, then j
        cyc(1, 1, JMP, 1, 0,  V_IDLE,    0, 0);
        cyc(1, 0, JMP, 0, 1,  V_FETCHNR, 0, 0);
        cyc(1, 0, JMP, 1, 1,  V_FETCH,   0, 0);
        cyc(1, 0, JMP, 1, 2,  V_DECODE,  0, 0);
        cyc(1, 0, JMP, 1, 11, V_JUMP,    0, 0);
        cyc(1, 0, JMP, 1, 1,  V_FETCH,   0, 1);

        // Let the monitor drain, with a bound.
        for (int i = 0; i < 4; i++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
            #1;
        end
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d records left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
